// File: rtl/approx_mult_pkg.sv
// Shared types and constants for the iterative approximate 8x8 multiplier.
// Holds FSM states, nibble step encodings and per-step shift amounts.
package approx_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] STEP_LL = 2'd0;
    localparam logic [1:0] STEP_LH = 2'd1;
    localparam logic [1:0] STEP_HL = 2'd2;
    localparam logic [1:0] STEP_HH = 2'd3;

    localparam logic [3:0] SH_LL = 4'd0;
    localparam logic [3:0] SH_LH = 4'd4;
    localparam logic [3:0] SH_HL = 4'd4;
    localparam logic [3:0] SH_HH = 4'd8;

    function automatic logic [3:0] step_shift(input logic [1:0] step);
        logic [3:0] sh;
        case (step)
            STEP_LL: sh = SH_LL;
            STEP_LH: sh = SH_LH;
            STEP_HL: sh = SH_HL;
            default: sh = SH_HH;
        endcase
        return sh;
    endfunction

endpackage

// File: rtl/approx4x4_core.sv
// Combinational approximate 4x4 multiplier: a*b[1:0] + 12*a*b[2].
// b[3] is deliberately ignored; the 12a term stands in for the upper bits.
module approx4x4_core (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    output logic [7:0] o_p
);

    logic [5:0] w_lo;
    logic [7:0] w_hi;

    assign w_lo = {2'b00, i_a} * {4'b0000, i_b[1:0]};
    assign w_hi = i_b[2] ? ({1'b0, i_a, 3'b000} + {2'b00, i_a, 2'b00}) : 8'd0;
    assign o_p  = {2'b00, w_lo} + w_hi;

endmodule

// File: rtl/approx_mult8x8_seq.sv
// Iterative 8x8 approximate multiplier sharing one 4x4 core over four nibble partials.
// Optional SKIP_LL_EN drops the LL partial and shortens the run to three steps.
module approx_mult8x8_seq
    import approx_mult_pkg::*;
#(
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_p,
    output logic             busy
);

`ifdef SKIP_LL_EN
    localparam logic [1:0] STEP_FIRST = STEP_LH;
`else
    localparam logic [1:0] STEP_FIRST = STEP_LL;
`endif

    state_t           r_state;
    logic [1:0]       r_step;
    logic [7:0]       r_a;
    logic [7:0]       r_b;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] r_out_p;
    logic             r_out_valid;

    logic [3:0]       w_ca;
    logic [3:0]       w_cb;
    logic [7:0]       w_prod;
    logic [15:0]      w_term16;
    logic [ACC_W-1:0] w_sum;

    // step[1] selects the a nibble, step[0] the b nibble
    assign w_ca = r_step[1] ? r_a[7:4] : r_a[3:0];
    assign w_cb = r_step[0] ? r_b[7:4] : r_b[3:0];

    approx4x4_core u_core (
        .i_a (w_ca),
        .i_b (w_cb),
        .o_p (w_prod)
    );

    assign w_term16 = {8'd0, w_prod} << step_shift(r_step);
    assign w_sum    = r_acc + ACC_W'(w_term16);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_step      <= 2'd0;
            r_a         <= 8'd0;
            r_b         <= 8'd0;
            r_acc       <= '0;
            r_out_p     <= '0;
            r_out_valid <= 1'b0;
        end else if (abort) begin
            r_state     <= IDLE;
            r_step      <= 2'd0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= in_a;
                        r_b     <= in_b;
                        r_acc   <= '0;
                        r_step  <= STEP_FIRST;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_acc  <= w_sum;
                    r_step <= r_step + 2'd1;
                    if (r_step == STEP_HH) begin
                        r_out_p     <= w_sum;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign out_valid = r_out_valid;
    assign out_p     = r_out_p;

endmodule

// File: tb/tb_approx_mult8x8_seq.sv
// Directed bench for approx_mult8x8_seq with hand-computed products.
// Expected values track SKIP_LL_EN by subtracting the LL partial.
module tb_approx_mult8x8_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        abort;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_p;
    logic        busy;

    int n_pass;
    int n_chk;

`ifdef SKIP_LL_EN
    localparam int LAT = 3;
    localparam bit SKIP = 1'b1;
`else
    localparam int LAT = 4;
    localparam bit SKIP = 1'b0;
`endif

    approx_mult8x8_seq #(.ACC_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic accept(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        check("in_ready_pre", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input string tag, input logic [15:0] full,
                               input logic [15:0] ll);
        int cyc;
        logic [15:0] exp;
        exp = SKIP ? (full - ll) : full;
        cyc = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                cyc = i;
                break;
            end
        end
        check({tag, "_lat"}, cyc, LAT);
        check({tag, "_p"}, {16'd0, out_p}, {16'd0, exp});
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("drain_ov", {31'd0, out_valid}, 32'd0);
        check("drain_rdy", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [7:0] a,
                          input logic [7:0] b, input logic [15:0] full,
                          input logic [15:0] ll);
        accept(a, b);
        wait_result(tag, full, ll);
        drain();
    endtask

    initial begin
        n_pass    = 0;
        n_chk     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = 8'd0;
        in_b      = 8'd0;
        abort     = 1'b0;
        out_ready = 1'b0;
        #2;
        check("rst_ready", {31'd0, in_ready}, 32'd1);
        check("rst_ov", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_p", {16'd0, out_p}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // basic products, LL partial listed for the skip build
        run_op("t1", 8'h12, 8'h34, 16'd1080, 16'd24);
        run_op("t2ff", 8'hFF, 8'hFF, 16'd65025, 16'd225);
        run_op("t2b3", 8'h08, 8'h08, 16'd0, 16'd0);
        run_op("t2x", 8'h34, 8'h12, 16'd936, 16'd8);
        run_op("t2y", 8'h05, 8'h07, 16'd75, 16'd75);

        // backpressure
        accept(8'h12, 8'h34);
        wait_result("t3", 16'd1080, 16'd24);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp_ov", {31'd0, out_valid}, 32'd1);
            check("bp_p", {16'd0, out_p}, SKIP ? 32'd1056 : 32'd1080);
            check("bp_rdy", {31'd0, in_ready}, 32'd0);
        end
        drain();

        // abort during step 2
        accept(8'hFF, 8'hFF);
        @(posedge clk);
        @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("ab_rdy", {31'd0, in_ready}, 32'd1);
        check("ab_busy", {31'd0, busy}, 32'd0);
        begin
            logic seen;
            seen = out_valid;
            for (int i = 0; i < 6; i++) begin
                @(posedge clk);
                #1;
                seen = seen | out_valid;
            end
            check("ab_noov", {31'd0, seen}, 32'd0);
        end
        run_op("t4", 8'h12, 8'h34, 16'd1080, 16'd24);

        // abort beats in_valid in IDLE
        @(negedge clk);
        in_valid = 1'b1;
        abort    = 1'b1;
        in_a     = 8'hFF;
        in_b     = 8'hFF;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        abort    = 1'b0;
        check("t5_busy", {31'd0, busy}, 32'd0);
        check("t5_rdy", {31'd0, in_ready}, 32'd1);

        // async reset mid-run
        accept(8'h12, 8'h34);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("t6_busy_pre", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_rdy", {31'd0, in_ready}, 32'd1);
        check("t6_busy", {31'd0, busy}, 32'd0);
        check("t6_ov", {31'd0, out_valid}, 32'd0);
        check("t6_p", {16'd0, out_p}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("t6a", 8'hFF, 8'hFF, 16'd65025, 16'd225);
        run_op("t6b", 8'h12, 8'h34, 16'd1080, 16'd24);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
